// File: rtl/hilo_acc_bank.sv
// hilo_acc_bank: bank of NUM_ACC HI/LO accumulator pairs behind a one-entry
// pending write stage, with read-side forwarding and sticky signed-overflow flags.
module hilo_acc_bank #(
  parameter  int DATA_W  = 32,
  parameter  int NUM_ACC = 4,
  localparam int IDX_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic [2*DATA_W-1:0] prod_i,
  input  logic                stall,
  input  logic                flush,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic [NUM_ACC-1:0]  ovf_o,
  output logic                pend_o,
  output logic                illegal_o
);

  localparam int ACC_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    OP_WRITE_BOTH = 3'b000,
    OP_WRITE_HI   = 3'b001,
    OP_WRITE_LO   = 3'b010,
    OP_ACC_ADD    = 3'b011,
    OP_ACC_SUB    = 3'b100
  } op_e;

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_sgn, input logic b_sgn, input logic r_sgn);
    return (a_sgn == b_sgn) && (r_sgn != a_sgn);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result leaves the minuend's sign.
  function automatic logic sub_ovf(input logic a_sgn, input logic b_sgn, input logic r_sgn);
    return (a_sgn != b_sgn) && (r_sgn != a_sgn);
  endfunction

  logic [DATA_W-1:0]  acc_hi_r [NUM_ACC];
  logic [DATA_W-1:0]  acc_lo_r [NUM_ACC];
  logic [NUM_ACC-1:0] ovf_r;
  logic               illegal_r;

  logic               p_valid_r;
  logic [IDX_W-1:0]   p_idx_r;
  logic [2:0]         p_op_r;
  logic [DATA_W-1:0]  p_hi_r;
  logic [DATA_W-1:0]  p_lo_r;
  logic [ACC_W-1:0]   p_prod_r;

  logic               accept_s;
  logic               commit_s;
  logic [ACC_W-1:0]   cur_acc_s;
  logic [ACC_W-1:0]   sum_s;
  logic [ACC_W-1:0]   diff_s;
  logic [DATA_W-1:0]  nxt_hi_s;
  logic [DATA_W-1:0]  nxt_lo_s;
  logic               nxt_ovf_s;
  logic               p_illegal_s;

  assign accept_s  = we && !stall && !flush;
  assign commit_s  = p_valid_r && !stall && !flush;

  // Arithmetic always reads the live array so back-to-back ACC ops chain without bubbles.
  assign cur_acc_s = {acc_hi_r[p_idx_r], acc_lo_r[p_idx_r]};
  assign sum_s     = cur_acc_s + p_prod_r;
  assign diff_s    = cur_acc_s - p_prod_r;

  // Value the pending entry would commit into its pair (also the forwarding source).
  always_comb begin
    nxt_hi_s    = acc_hi_r[p_idx_r];
    nxt_lo_s    = acc_lo_r[p_idx_r];
    nxt_ovf_s   = ovf_r[p_idx_r];
    p_illegal_s = 1'b0;
    case (p_op_r)
      OP_WRITE_BOTH: begin
        nxt_hi_s  = p_hi_r;
        nxt_lo_s  = p_lo_r;
        nxt_ovf_s = 1'b0;
      end
      OP_WRITE_HI: begin
        nxt_hi_s = p_hi_r;
      end
      OP_WRITE_LO: begin
        nxt_lo_s = p_lo_r;
      end
      OP_ACC_ADD: begin
        {nxt_hi_s, nxt_lo_s} = sum_s;
        nxt_ovf_s = ovf_r[p_idx_r] |
                    add_ovf(cur_acc_s[ACC_W-1], p_prod_r[ACC_W-1], sum_s[ACC_W-1]);
      end
      OP_ACC_SUB: begin
        {nxt_hi_s, nxt_lo_s} = diff_s;
        nxt_ovf_s = ovf_r[p_idx_r] |
                    sub_ovf(cur_acc_s[ACC_W-1], p_prod_r[ACC_W-1], diff_s[ACC_W-1]);
      end
      default: begin
        p_illegal_s = 1'b1;
      end
    endcase
  end

  // Read port: a valid pending entry for the selected pair wins, regardless of stall/flush.
  always_comb begin
    if (p_valid_r && (rd_idx == p_idx_r)) begin
      hi_o = nxt_hi_s;
      lo_o = nxt_lo_s;
    end else begin
      hi_o = acc_hi_r[rd_idx];
      lo_o = acc_lo_r[rd_idx];
    end
  end

  // Pending stage: flush kills, stall holds, otherwise load (or empty) each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_valid_r <= 1'b0;
      p_idx_r   <= {IDX_W{1'b0}};
      p_op_r    <= 3'b000;
      p_hi_r    <= {DATA_W{1'b0}};
      p_lo_r    <= {DATA_W{1'b0}};
      p_prod_r  <= {ACC_W{1'b0}};
    end else if (flush) begin
      p_valid_r <= 1'b0;
    end else if (stall) begin
      p_valid_r <= p_valid_r;
    end else begin
      p_valid_r <= accept_s;
      if (accept_s) begin
        p_idx_r  <= wr_idx;
        p_op_r   <= op;
        p_hi_r   <= hi_i;
        p_lo_r   <= lo_i;
        p_prod_r <= prod_i;
      end
    end
  end

  // Accumulator array and sticky overflow flags; illegal ops recommit the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_hi_r[i] <= {DATA_W{1'b0}};
        acc_lo_r[i] <= {DATA_W{1'b0}};
      end
      ovf_r <= {NUM_ACC{1'b0}};
    end else if (commit_s) begin
      acc_hi_r[p_idx_r] <= nxt_hi_s;
      acc_lo_r[p_idx_r] <= nxt_lo_s;
      ovf_r[p_idx_r]    <= nxt_ovf_s;
    end
  end

  // One-cycle pulse following the commit of an illegal op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= commit_s && p_illegal_s;
    end
  end

  assign ovf_o     = ovf_r;
  assign pend_o    = p_valid_r;
  assign illegal_o = illegal_r;

endmodule
